adder_scheduler: RTL and testbench
==================================

Name: adder_scheduler

Overview:
Sequences and shares one sixteenBitAdder instance between two requesters. Each requester submits an operation over a valid/ready handshake:
- 16-bit add
- dual independent 8-bit add (carry between bytes broken via the adder's split input)
- 32-bit add, executed as two chained 16-bit passes

The block arbitrates between requesters, drives the adder ports, registers results and returns them over a valid/ready result channel tagged with the requester ID.

Parameters:
PRIO_FIXED, 0, 0 = round-robin arbitration; 1 = req0 always wins when both requesters are valid.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a, req0_b  input  32  operands (bits 31:16 used only in ADD32)
req0_ci  input  1  carry-in
req0_mode  input  2  00 ADD16, 01 DUAL8, 10 ADD32, 11 reserved
req1_valid, req1_ready, req1_a, req1_b, req1_ci, req1_mode  —  same as requester 0
add_a, add_b  output  16 ([0:15])  adder operands; index 0:7 = low byte (Ci side)
add_ci  output  1  adder carry-in
add_split  output  1  1 = byte carry propagates, 0 = broken
add_s  input  16 ([0:15])  adder sum (combinational)
add_co  input  1  adder carry-out
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_sum  output  32  result; bits 31:16 are zero unless ADD32
res_co  output  1  final carry-out
res_id  output  1  requester that issued the op
res_err  output  1  reserved mode was used
busy  output  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC_LO, EXEC_HI, RESP. Reset (async, rst_n=0) forces:
  - state = IDLE, RR pointer = req0;
  - all outputs 0 except add_split = 1.
  - Reset mid-operation discards the operation; no result is produced.
- IDLE:
  - Arbitration:
    - Only one requester valid: it wins.
    - Both valid, PRIO_FIXED=0: the winner is the RR pointer's requester.
    - Both valid, PRIO_FIXED=1: req0 wins.
  - reqX_ready is asserted combinationally for the winner only; ready is never asserted outside IDLE.
  - On handshake: latch a, b, ci, mode and id, then go to EXEC_LO.
- EXEC_LO:
  - Drive add_a/add_b = latched bits 15:0 and add_ci = latched ci.
  - add_split = 0 for DUAL8, otherwise 1.
  - Register add_s into res[15:0] and add_co into the carry register.
  - Next state is EXEC_HI if mode = ADD32, otherwise RESP.
- EXEC_HI:
  - Drive bits 31:16, add_ci = carry register, add_split = 1.
  - Register res[31:16] and the carry; go to RESP.
- RESP:
  - res_valid = 1; res_sum/res_co/res_id/res_err are held stable until res_ready = 1.
  - On res_valid & res_ready: go to IDLE and set the RR pointer to the requester other than res_id.
  - res_valid deasserts the cycle after acceptance. An accept in IDLE can occur in that same cycle (back-to-back).
- Mode 11 executes as ADD16 with res_err = 1.
- In DUAL8 the low-byte carry is discarded; res_co = high-byte carry.
- Outside EXEC states, add_a/add_b/add_ci = 0 and add_split = 1.
- Latency, with the handshake in cycle N:
  - ADD16 / DUAL8: res_valid in cycle N+2.
  - ADD32: res_valid in cycle N+3.
- Throughput: one operation per 3 cycles (ADD16) or 4 cycles (ADD32) when res_ready is held high.
- Requester operands need not be held after their handshake.

Test Plan:
- ADD16: req0 a=0x1234, b=0x0FFF, ci=0 → res_sum=0x00002233, res_co=0, res_id=0, res_valid in N+2.
- DUAL8 vs ADD16: a=0x00FF, b=0x0001, ci=0:
  - DUAL8 → res_sum=0x0000, co=0, add_split=0 observed in EXEC_LO;
  - ADD16 → res_sum=0x0100.
- ADD32 carry chain:
  - 0x0000FFFF+0x00000001 → 0x00010000, co=0;
  - 0xFFFFFFFF+0x00000001, ci=0 → 0x00000000, co=1, res_valid in N+3.
- Arbitration: both requesters valid continuously, PRIO_FIXED=0 → grants 0,1,0,1. With PRIO_FIXED=1 → grants 0,0,0.
- Backpressure and reserved mode: res_ready low for 5 cycles → result fields stable, busy=1, no reqX_ready. Mode 11 → ADD16 sum with res_err=1.
- Reset mid-operation: assert rst_n=0 during EXEC_HI → all outputs 0 immediately. After release: IDLE, RR pointer = req0, no stale res_valid.

Source files
------------

// File: rtl/adder_scheduler_if.sv
// Bundled handshake and adder-port signals for adder_scheduler.
// The adder buses use [0:15] ordering, so index 0 is the least significant (carry-in side) bit.
interface adder_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ci;
  logic [1:0]  req0_mode;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ci;
  logic [1:0]  req1_mode;

  logic [0:15] add_a;
  logic [0:15] add_b;
  logic        add_ci;
  logic        add_split;
  logic [0:15] add_s;
  logic        add_co;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_co;
  logic        res_id;
  logic        res_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ci, req0_mode,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ci, req1_mode,
    output req1_ready,
    output add_a, add_b, add_ci, add_split,
    input  add_s, add_co,
    output res_valid, res_sum, res_co, res_id, res_err,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ci, req0_mode,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ci, req1_mode,
    input  req1_ready,
    input  add_a, add_b, add_ci, add_split,
    output add_s, add_co,
    input  res_valid, res_sum, res_co, res_id, res_err,
    output res_ready
  );
endinterface

// File: rtl/adder_scheduler.sv
// Shares one external 16-bit adder between two requesters: ADD16, DUAL8 and
// two-pass ADD32 operations, with results returned over a valid/ready channel.
module adder_scheduler #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_scheduler_if.slave    bus,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;

  localparam logic [1:0] MODE_DUAL8 = 2'b01;
  localparam logic [1:0] MODE_ADD32 = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        ci_q, ci_d;
  logic [1:0]  mode_q, mode_d;
  logic        id_q, id_d;
  logic [31:0] sum_q, sum_d;
  logic        co_q, co_d;

  logic        grant0, grant1;
  logic [15:0] op_a, op_b;
  logic [15:0] s_vec;

  // Grants are masked by rst_n so ready stays low while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (PRIO_FIXED || !rr_q) grant0 = 1'b1;
        else                     grant1 = 1'b1;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  // Adder drive depends on registered state only, keeping it free of add_s feedback.
  always_comb begin
    op_a          = '0;
    op_b          = '0;
    bus.add_ci    = 1'b0;
    bus.add_split = 1'b1;
    case (state_q)
      EXEC_LO: begin
        op_a          = a_q[15:0];
        op_b          = b_q[15:0];
        bus.add_ci    = ci_q;
        bus.add_split = (mode_q != MODE_DUAL8);
      end
      EXEC_HI: begin
        op_a       = a_q[31:16];
        op_b       = b_q[31:16];
        bus.add_ci = co_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      bus.add_a[i] = op_a[i];
      bus.add_b[i] = op_b[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      s_vec[i] = bus.add_s[i];
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    mode_d  = mode_q;
    id_d    = id_q;
    sum_d   = sum_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          a_d     = grant1 ? bus.req1_a    : bus.req0_a;
          b_d     = grant1 ? bus.req1_b    : bus.req0_b;
          ci_d    = grant1 ? bus.req1_ci   : bus.req0_ci;
          mode_d  = grant1 ? bus.req1_mode : bus.req0_mode;
          id_d    = grant1;
          state_d = EXEC_LO;
        end
      end
      EXEC_LO: begin
        // With split low the adder's own carry-out is already the high-byte carry.
        sum_d   = {16'h0000, s_vec};
        co_d    = bus.add_co;
        state_d = (mode_q == MODE_ADD32) ? EXEC_HI : RESP;
      end
      EXEC_HI: begin
        sum_d   = {s_vec, sum_q[15:0]};
        co_d    = bus.add_co;
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          state_d = IDLE;
          rr_d    = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      mode_q  <= '0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.res_valid  = (state_q == RESP);
  assign bus.res_sum    = bus.res_valid ? sum_q : '0;
  assign bus.res_co     = bus.res_valid & co_q;
  assign bus.res_id     = bus.res_valid & id_q;
  assign bus.res_err    = bus.res_valid & (mode_q == MODE_RSVD);
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed bench for adder_scheduler: a behavioural 16-bit adder, an arithmetic
// reference pushed to a scoreboard at each handshake, and a round-robin and a fixed-priority instance.
module tb_adder_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  adder_scheduler_if bus0 ();
  adder_scheduler_if bus1 ();
  logic busy0, busy1;

  adder_scheduler #(.PRIO_FIXED(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0));
  adder_scheduler #(.PRIO_FIXED(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        id;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [16:0] adder_fn(input logic [0:15] a, input logic [0:15] b,
                                           input logic ci, input logic split);
    logic [7:0] al, ah, bl, bh;
    logic [8:0] lo, hi;
    for (int i = 0; i < 8; i++) begin
      al[i] = a[i];
      ah[i] = a[i+8];
      bl[i] = b[i];
      bh[i] = b[i+8];
    end
    lo = {1'b0, al} + {1'b0, bl} + {8'h00, ci};
    hi = {1'b0, ah} + {1'b0, bh} + {8'h00, split & lo[8]};
    return {hi[8], hi[7:0], lo[7:0]};
  endfunction

  logic [16:0] r0, r1;
  always_comb begin
    r0 = adder_fn(bus0.add_a, bus0.add_b, bus0.add_ci, bus0.add_split);
    bus0.add_co = r0[16];
    for (int i = 0; i < 16; i++) bus0.add_s[i] = r0[i];
  end
  always_comb begin
    r1 = adder_fn(bus1.add_a, bus1.add_b, bus1.add_ci, bus1.add_split);
    bus1.add_co = r1[16];
    for (int i = 0; i < 16; i++) bus1.add_s[i] = r1[i];
  end

  function automatic exp_t expect_fn(input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, input logic [1:0] mode, input logic id);
    exp_t e;
    logic [16:0] s16;
    logic [8:0]  lo, hi;
    logic [32:0] s32;
    e.id  = id;
    e.err = (mode == 2'b11);
    case (mode)
      2'b01: begin
        lo    = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, ci};
        hi    = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        e.sum = {16'h0000, hi[7:0], lo[7:0]};
        e.co  = hi[8];
      end
      2'b10: begin
        s32   = {1'b0, a} + {1'b0, b} + {32'h0, ci};
        e.sum = s32[31:0];
        e.co  = s32[32];
      end
      default: begin
        s16   = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'h0000, ci};
        e.sum = {16'h0000, s16[15:0]};
        e.co  = s16[16];
      end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus0.res_valid && bus0.res_ready) begin
      check("sb_result_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_sum", bus0.res_sum, e.sum);
        check("sb_co_id_err", {bus0.res_co, bus0.res_id, bus0.res_err}, {e.co, e.id, e.err});
      end
    end
  end

  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic [1:0] mode, input bit push, output int n);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (id) begin
      bus0.req1_valid = 1'b1; bus0.req1_a = a; bus0.req1_b = b;
      bus0.req1_ci = ci; bus0.req1_mode = mode;
    end else begin
      bus0.req0_valid = 1'b1; bus0.req0_a = a; bus0.req0_b = b;
      bus0.req0_ci = ci; bus0.req0_mode = mode;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = id ? bus0.req1_ready : bus0.req0_ready;
    end
    check("handshake_seen", 64'(got), 64'd1);
    n = cyc;
    if (push) sb.push_back(expect_fn(a, b, ci, mode, id));
    @(posedge clk); #1;
    // Operands are scrambled after the handshake; the DUT must have latched them.
    bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
    bus0.req0_a = 32'hDEAD_BEEF; bus0.req0_b = 32'hBEEF_DEAD;
    bus0.req1_a = 32'hDEAD_BEEF; bus0.req1_b = 32'hBEEF_DEAD;
  endtask

  task automatic wait_res(input int n, input int lat_exp, input string tag);
    bit got;
    int lat;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus0.res_valid) begin
        got = 1'b1;
        lat = cyc - n;
      end
    end
    check(tag, 64'(lat), 64'(lat_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g[4];
    int ng;

    bus0.req0_valid = 1'b0; bus0.req0_a = '0; bus0.req0_b = '0; bus0.req0_ci = 1'b0; bus0.req0_mode = '0;
    bus0.req1_valid = 1'b0; bus0.req1_a = '0; bus0.req1_b = '0; bus0.req1_ci = 1'b0; bus0.req1_mode = '0;
    bus0.res_ready  = 1'b1;
    bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_ci = 1'b0; bus1.req0_mode = '0;
    bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_ci = 1'b0; bus1.req1_mode = '0;
    bus1.res_ready  = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_ctrl", {bus0.res_valid, busy0, bus0.add_ci, bus0.add_split, bus0.add_a, bus0.add_b},
          {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000});
    check("reset_res", {bus0.res_sum, bus0.res_co, bus0.res_id, bus0.res_err}, 35'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    send(1'b0, 32'h0000_1234, 32'h0000_0FFF, 1'b0, 2'b00, 1'b1, n);
    wait_res(n, 2, "add16_latency");
    check("add16_sum", bus0.res_sum, 32'h0000_2233);
    check("add16_co_id", {bus0.res_co, bus0.res_id}, 2'b00);

    send(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 2'b01, 1'b1, n);
    @(negedge clk);
    check("dual8_split_lo", {bus0.add_split, busy0}, 2'b01);
    wait_res(n, 2, "dual8_latency");
    check("dual8_sum", bus0.res_sum, 32'h0000_0000);

    send(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 2'b00, 1'b1, n);
    wait_res(n, 2, "add16_b_latency");
    check("add16_b_sum", bus0.res_sum, 32'h0000_0100);

    send(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 2'b10, 1'b1, n);
    wait_res(n, 3, "add32_a_latency");
    check("add32_a_sum", {bus0.res_sum, bus0.res_co}, {32'h0001_0000, 1'b0});

    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b10, 1'b1, n);
    wait_res(n, 3, "add32_b_latency");
    check("add32_b_sum", {bus0.res_sum, bus0.res_co}, {32'h0000_0000, 1'b1});

    send(1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 2'b01, 1'b1, n);
    wait_res(n, 2, "dual8_b_latency");

    @(posedge clk); #1;
    bus0.res_ready = 1'b0;
    send(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0, 2'b11, 1'b1, n);
    wait_res(n, 2, "rsvd_latency");
    bus0.req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", {bus0.res_valid, bus0.res_sum, bus0.res_err, busy0, bus0.req0_ready, bus0.req1_ready},
            {1'b1, 32'd12, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    bus0.req1_valid = 1'b0;
    bus0.res_ready  = 1'b1;
    repeat (3) @(negedge clk);

    send(1'b0, 32'h0001_0001, 32'h0002_0002, 1'b0, 2'b10, 1'b0, n);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_hi_busy", {busy0, bus0.add_a}, {1'b1, 16'h8000});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {bus0.res_valid, busy0, bus0.req0_ready, bus0.req1_ready, bus0.add_ci,
                             bus0.add_split, bus0.add_a, bus0.add_b},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000});
    check("rst_async_res", {bus0.res_sum, bus0.res_co, bus0.res_id, bus0.res_err}, 35'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_idle", {bus0.res_valid, busy0}, 2'b00);
    end

    @(posedge clk); #1;
    bus0.req0_valid = 1'b1; bus0.req0_a = 32'h0000_0010; bus0.req0_b = 32'h0000_0020;
    bus0.req0_ci = 1'b0; bus0.req0_mode = 2'b00;
    bus0.req1_valid = 1'b1; bus0.req1_a = 32'h0000_1000; bus0.req1_b = 32'h0000_0300;
    bus0.req1_ci = 1'b1; bus0.req1_mode = 2'b00;
    g = '{-1, -1, -1, -1};
    ng = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      @(negedge clk);
      if (bus0.req0_ready) begin
        g[ng] = 0; ng++;
        sb.push_back(expect_fn(32'h0000_0010, 32'h0000_0020, 1'b0, 2'b00, 1'b0));
      end else if (bus0.req1_ready) begin
        g[ng] = 1; ng++;
        sb.push_back(expect_fn(32'h0000_1000, 32'h0000_0300, 1'b1, 2'b00, 1'b1));
      end
    end
    @(posedge clk); #1;
    bus0.req0_valid = 1'b0;
    bus0.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 64'(g[i]), 64'(i % 2));
    repeat (8) @(negedge clk);

    @(posedge clk); #1;
    bus1.req0_valid = 1'b1; bus1.req0_a = 32'h0000_0001; bus1.req0_b = 32'h0000_0002;
    bus1.req1_valid = 1'b1; bus1.req1_a = 32'h0000_0003; bus1.req1_b = 32'h0000_0004;
    g = '{-1, -1, -1, -1};
    ng = 0;
    for (int k = 0; k < 60 && ng < 3; k++) begin
      @(negedge clk);
      if (bus1.req0_ready) begin
        g[ng] = 0; ng++;
      end else if (bus1.req1_ready) begin
        g[ng] = 1; ng++;
      end
    end
    @(posedge clk); #1;
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) check($sformatf("fixed_grant%0d", i), 64'(g[i]), 64'd0);

    repeat (10) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
